dmem: RTL and testbench
=======================

# dmem

Parametrised synchronous data memory for the RISC-V core. It generalises the single-width word RAM to a byte-addressed, byte-lane-enabled memory. It executes all RV32I load and store sizes (LB/LH/LW/LBU/LHU, SB/SH/SW) directly from funct3, with registered sign/zero extension and misalignment detection. It sits in the MEM stage between the ALU address output and the writeback mux.

## Interface
- `DEPTH_LOG2`, default 10: memory depth in 32-bit words (2^DEPTH_LOG2 words).
- `XLEN`, default 32: data width; only 32 is supported, and elaboration must fail otherwise.
- `clock`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `ramR`  in  1  load request this cycle.
- `ramW`  in  1  store request this cycle.
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; all other codes are illegal.
- `addr`  in  32  byte address; bits [DEPTH_LOG2+1:2] select the word and bits [1:0] select the byte; upper bits are ignored (address wraps).
- `dataW`  in  32  store data; the low byte/half/word is used according to size.
- `dataR`  out  32  extended load result.
- `rvalid`  out  1  `dataR` holds a new load result.
- `fault`  out  1  the previous request was misaligned or illegal (only with the macro, see Configuration).

## Operation
- Storage: 2^DEPTH_LOG2 × 4 byte lanes. Contents are not cleared by `reset`.
- Store (`ramW`=1), per-lane write enables:
  - SB: lane = `addr[1:0]`, data `dataW[7:0]` replicated to all lanes.
  - SH: lanes {`addr[1]`*2, +1}, data `dataW[15:0]` replicated.
  - SW: all lanes.
- Load (`ramR`=1): the full word is read. `addr[1:0]` and `funct3` are registered alongside it. Next cycle, the lane is selected, right-shifted, and then:
  - B/H: sign-extended.
  - BU/HU: zero-extended.
  - W: passed through.
- `ramR` and `ramW` both high to the same word: read-first. `dataR` returns the pre-write contents. Both operations execute.
- `ramR` and `ramW` both high to different words: both execute independently.
- Illegal `funct3` with `ramR` or `ramW`: no lanes are written. The load returns 0 with `rvalid`=1.
- `dataR` holds its last value when `rvalid`=0.

## Timing
- Store: committed at the rising edge where `ramW`=1. A load issued the following cycle sees the new data.
- Load latency: 1 cycle. Request sampled at edge N; `dataR`/`rvalid` are valid after edge N, for the cycle N..N+1.
- `rvalid` is high exactly one cycle per accepted load. Back-to-back loads give back-to-back `rvalid` pulses.
- `reset` at edge N:
  - `dataR`=0, `rvalid`=0, `fault`=0.
  - A load sampled at the same edge is discarded.
  - A store sampled at the same edge is suppressed.
- No stalls or backpressure: the block accepts one request per cycle unconditionally.

## Configuration
- Macro `DMEM_MISALIGN_TRAP_EN`.
- Defined:
  - A halfword access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, is misaligned.
  - A misaligned store writes nothing. A misaligned load returns 0.
  - `fault` pulses high for 1 cycle, aligned with the `rvalid` timing, for misaligned or illegal-funct3 requests.
- Undefined:
  - The low address bits are forced aligned (H: bit 0 cleared; W: bits [1:0] cleared) and the access proceeds.
  - `fault` is tied to 0. The port remains so the top level is unchanged.

## Structure
- Package `riscv_pkg` holds:
  - funct3 load/store constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - Enum `mem_size_t` {SZ_B, SZ_H, SZ_W}.
  - Function `is_misaligned(size, addr[1:0])`.
- Sub-module `dmem_load_ext` is combinational. It takes the registered word, byte offset and funct3, and produces the 32-bit extended result. It is instantiated on the read path after the storage register.
- Storage is a single array of 4-lane words written with per-lane enables, so it infers block RAM with byte enables.

## Test plan
- SW 0x80FF_7F01 to 0x10; then LW, LB, LBU, LH, LHU from 0x10/0x11/0x12 → 0x80FF7F01, 0x00000001, 0x0000007F (LBU 0x11), 0xFFFFFF80 (LB 0x13), 0xFFFF80FF (LH 0x12), 0x000080FF (LHU 0x12), each with `rvalid` one cycle after the request.
- Word 0x20 holds 0; SB 0xAB to 0x21, then SH 0x1234 to 0x22 → LW 0x20 returns 0x1234AB00.
- SW 0xDEADBEEF to 0x30. Next cycle: `ramR`+`ramW` to 0x30 with 0x11111111 → `dataR`=0xDEADBEEF. A following LW → 0x11111111.
- With `DMEM_MISALIGN_TRAP_EN`: SW 0xFFFFFFFF to 0x41 → memory unchanged and `fault`=1 for one cycle. LH from 0x43 → `dataR`=0, `fault`=1. Without the macro: the same SW writes word 0x40, and `fault` stays 0.
- Assert `reset` on the same edge as LW 0x10 → `rvalid`, `dataR` and `fault` all 0 the next cycle. Memory contents persist; a subsequent LW 0x10 returns the prior value.
- Address wrap: with `DEPTH_LOG2`=4, SW 0xCAFEF00D to 0x40 → LW 0x00 returns 0xCAFEF00D.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared load/store definitions for the MEM stage: funct3 size codes,
// the access-size enum and the alignment helpers used by dmem.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } mem_size_t;

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(mem_size_t size, logic [1:0] off);
        case (size)
            SZ_H:    return off[0];
            SZ_W:    return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Rounds the byte offset down to the natural boundary of the access size.
    function automatic logic [1:0] align_offset(mem_size_t size, logic [1:0] off);
        case (size)
            SZ_H:    return {off[1], 1'b0};
            SZ_W:    return 2'b00;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage and the data memory.
// The core side uses the master modport, the memory uses slave.
interface dmem_if;

    logic        ramR;
    logic        ramW;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] dataW;
    logic [31:0] dataR;
    logic        rvalid;
    logic        fault;

    modport master (
        output ramR, ramW, funct3, addr, dataW,
        input  dataR, rvalid, fault
    );

    modport slave (
        input  ramR, ramW, funct3, addr, dataW,
        output dataR, rvalid, fault
    );

endinterface

// File: rtl/dmem_load_ext.sv
// Load result formatter: picks the addressed byte/halfword out of the
// registered word and sign- or zero-extends it according to funct3.
module dmem_load_ext
    import riscv_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [15:0] w_low;

    assign w_low = 16'(i_word >> {i_off, 3'b000});

    // Extension by access size; unknown codes pass the (zeroed) word through.
    always_comb begin
        o_data = i_word;
        case (i_funct3)
            F3_B:    o_data = {{24{w_low[7]}}, w_low[7:0]};
            F3_BU:   o_data = {24'h000000, w_low[7:0]};
            F3_H:    o_data = {{16{w_low[15]}}, w_low};
            F3_HU:   o_data = {16'h0000, w_low};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/dmem.sv
// Byte-addressed RV32I data memory with byte-lane write enables, one-cycle
// registered loads and funct3-driven size/sign handling. Loads are
// read-first with respect to a store in the same cycle.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses are rejected and reported on fault; otherwise the
// low address bits are forced aligned and fault is tied low.
module dmem
    import riscv_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int XLEN       = 32
) (
    input  logic  clock,
    input  logic  reset,
    dmem_if.slave bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    if (XLEN != 32) begin : g_xlen_check
        $error("dmem: only XLEN=32 is supported");
    end

    logic [3:0][7:0]       r_mem [DEPTH];
    logic [31:0]           r_rword;
    logic [1:0]            r_off;
    logic [2:0]            r_funct3;
    logic                  r_rvalid;

    logic [DEPTH_LOG2-1:0] w_idx;
    mem_size_t             w_size;
    logic                  w_legal;
    logic [1:0]            w_off;
    logic                  w_bad;
    logic [3:0]            w_be;
    logic [3:0][7:0]       w_wdata;
    logic [31:0]           w_ext;
    logic                  w_unused_addr;

    assign w_idx         = bus.addr[DEPTH_LOG2+1:2];
    assign w_unused_addr = ^bus.addr[31:DEPTH_LOG2+2];

    // Decode funct3 into access size and legality.
    always_comb begin
        w_legal = 1'b1;
        w_size  = SZ_W;
        case (bus.funct3)
            F3_B, F3_BU: w_size = SZ_B;
            F3_H, F3_HU: w_size = SZ_H;
            F3_W:        w_size = SZ_W;
            default:     w_legal = 1'b0;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic r_fault;

    assign w_off = bus.addr[1:0];
    assign w_bad = !w_legal || is_misaligned(w_size, bus.addr[1:0]);

    // One-cycle fault pulse for any rejected load or store request.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= (bus.ramR || bus.ramW) && w_bad;
        end
    end

    assign bus.fault = r_fault;
`else
    assign w_off     = align_offset(w_size, bus.addr[1:0]);
    assign w_bad     = !w_legal;
    assign bus.fault = 1'b0;
`endif

    // Lane enables and lane-replicated store data; rejected or reset-time stores write nothing.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = bus.dataW;
        case (w_size)
            SZ_B: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{bus.dataW[7:0]}};
            end
            SZ_H: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.dataW[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = bus.dataW;
            end
        endcase
        if (!bus.ramW || reset || w_bad) begin
            w_be = 4'b0000;
        end
    end

    // Byte-enabled storage write; contents survive reset.
    always_ff @(posedge clock) begin
        for (int l = 0; l < 4; l++) begin
            if (w_be[l]) begin
                r_mem[w_idx][l] <= w_wdata[l];
            end
        end
    end

    // Read register: captures the pre-write word plus offset/size for the extender.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rword  <= '0;
            r_off    <= 2'b00;
            r_funct3 <= F3_W;
        end else begin
            r_rvalid <= bus.ramR;
            if (bus.ramR) begin
                r_rword  <= w_bad ? '0 : r_mem[w_idx];
                r_off    <= w_off;
                r_funct3 <= bus.funct3;
            end
        end
    end

    dmem_load_ext u_load_ext (
        .i_word   (r_rword),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    assign bus.dataR  = w_ext;
    assign bus.rvalid = r_rvalid;

endmodule

// File: tb/tb_dmem.sv
// Testbench for dmem: directed vector table, hand-written sequences for
// misalignment, reset and address wrap, then random traffic against a
// byte-array reference model.
module tb_dmem;
    import riscv_pkg::*;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dmem_if bus ();
    dmem_if bus_w ();

    dmem #(.DEPTH_LOG2(10), .XLEN(32)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    dmem #(.DEPTH_LOG2(4), .XLEN(32)) u_dut_w (
        .clock (clock),
        .reset (reset),
        .bus   (bus_w)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: flat byte array, last load result, valid/fault flags.
    logic [7:0]  m_mem [4096];
    logic [31:0] m_data  = '0;
    bit          m_valid = 1'b0;
    bit          m_fault = 1'b0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] ed;
        bit          ev;
        bit          ef;
    } vec_t;

    vec_t vt[$];

    function automatic void addv(bit rd, bit wr, logic [2:0] f3, logic [31:0] a,
                                 logic [31:0] wd, logic [31:0] ed, bit ev, bit ef);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd;
        v.ed = ed; v.ev = ev; v.ef = ef;
        vt.push_back(v);
    endfunction

    function automatic void model_step(bit rst, bit rd, bit wr, logic [2:0] f3,
                                       logic [31:0] a, logic [31:0] wd);
        int n;
        int base;
        bit sgn;
        bit bad;
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: n = 1;
            3'b001, 3'b101: n = 2;
            3'b010:         n = 4;
            default:        n = 0;
        endcase
        sgn  = (f3[2] == 1'b0);
        bad  = (n == 0);
        base = int'(a & 32'h0000_0FFF);
        if (n > 0 && (base % n) != 0) begin
            if (TRAP) bad = 1'b1;
            else      base = base - (base % n);
        end
        if (rst) begin
            m_data  = '0;
            m_valid = 1'b0;
            m_fault = 1'b0;
            return;
        end
        m_valid = rd;
        m_fault = TRAP && (rd || wr) && bad;
        if (rd) begin
            if (bad) begin
                m_data = '0;
            end else begin
                v = '0;
                for (int k = 0; k < n; k++) v = v | (32'(m_mem[base + k]) << (8 * k));
                if (sgn && n == 1) v = {{24{v[7]}}, v[7:0]};
                if (sgn && n == 2) v = {{16{v[15]}}, v[15:0]};
                m_data = v;
            end
        end
        if (wr && !bad) begin
            for (int k = 0; k < n; k++) m_mem[base + k] = wd[8*k +: 8];
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request, advance one edge, update model, sample at edge+1.
    task automatic do_cycle(input bit rst, input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
        reset      = rst;
        bus.ramR   = rd;
        bus.ramW   = wr;
        bus.funct3 = f3;
        bus.addr   = a;
        bus.dataW  = wd;
        @(posedge clock);
        model_step(rst, rd, wr, f3, a, wd);
        #1;
    endtask

    task automatic chk_model(input string name);
        chk({name, ".dataR"},  bus.dataR, m_data);
        chk({name, ".rvalid"}, 32'(bus.rvalid), 32'(m_valid));
        chk({name, ".fault"},  32'(bus.fault), 32'(m_fault));
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        bus.ramR = 0; bus.ramW = 0; bus.funct3 = F3_W; bus.addr = 0; bus.dataW = 0;
        bus_w.ramR = 0; bus_w.ramW = 0; bus_w.funct3 = F3_W; bus_w.addr = 0; bus_w.dataW = 0;

        do_cycle(1, 0, 0, F3_W, 0, 0);
        do_cycle(1, 0, 0, F3_W, 0, 0);
        chk("reset.dataR",  bus.dataR, 32'h0);
        chk("reset.rvalid", 32'(bus.rvalid), 32'h0);
        chk("reset.fault",  32'(bus.fault), 32'h0);

        // Address wrap on the 16-word instance; main instance idle.
        reset = 0;
        bus.ramR = 0; bus.ramW = 0;
        bus_w.ramW = 1; bus_w.funct3 = F3_W; bus_w.addr = 32'h40; bus_w.dataW = 32'hCAFEF00D;
        @(posedge clock); #1;
        bus_w.ramW = 0; bus_w.ramR = 1; bus_w.addr = 32'h00;
        @(posedge clock); #1;
        chk("wrap.dataR",  bus_w.dataR, 32'hCAFEF00D);
        chk("wrap.rvalid", 32'(bus_w.rvalid), 32'h1);
        bus_w.ramR = 0;
        @(posedge clock); #1;
        chk("wrap.rvalid_drop", 32'(bus_w.rvalid), 32'h0);

        // Known contents everywhere so the model matches the RAM.
        for (int w = 0; w < 1024; w++) do_cycle(0, 0, 1, F3_W, 32'(w * 4), 32'(w) * 32'h9E3779B9);
        do_cycle(1, 0, 0, F3_W, 0, 0);

        addv(0, 1, F3_W,   32'h10, 32'h80FF7F01, 32'h00000000, 0, 0);
        addv(1, 0, F3_W,   32'h10, 32'h0,        32'h80FF7F01, 1, 0);
        addv(1, 0, F3_B,   32'h10, 32'h0,        32'h00000001, 1, 0);
        addv(1, 0, F3_BU,  32'h11, 32'h0,        32'h0000007F, 1, 0);
        addv(1, 0, F3_B,   32'h13, 32'h0,        32'hFFFFFF80, 1, 0);
        addv(1, 0, F3_H,   32'h12, 32'h0,        32'hFFFF80FF, 1, 0);
        addv(1, 0, F3_HU,  32'h12, 32'h0,        32'h000080FF, 1, 0);
        addv(0, 1, F3_W,   32'h20, 32'h0,        32'h000080FF, 0, 0);
        addv(0, 1, F3_B,   32'h21, 32'h000000AB, 32'h000080FF, 0, 0);
        addv(0, 1, F3_H,   32'h22, 32'h00001234, 32'h000080FF, 0, 0);
        addv(1, 0, F3_W,   32'h20, 32'h0,        32'h1234AB00, 1, 0);
        addv(0, 1, F3_W,   32'h30, 32'hDEADBEEF, 32'h1234AB00, 0, 0);
        addv(1, 1, F3_W,   32'h30, 32'h11111111, 32'hDEADBEEF, 1, 0);
        addv(1, 0, F3_W,   32'h30, 32'h0,        32'h11111111, 1, 0);
        addv(0, 0, F3_W,   32'h30, 32'h0,        32'h11111111, 0, 0);
        addv(1, 0, 3'b011, 32'h10, 32'h0,        32'h00000000, 1, TRAP);
        addv(0, 1, 3'b111, 32'h10, 32'hFFFFFFFF, 32'h00000000, 0, TRAP);
        addv(1, 0, F3_W,   32'h10, 32'h0,        32'h80FF7F01, 1, 0);
        addv(1, 0, F3_BU,  32'h13, 32'h0,        32'h00000080, 1, 0);
        addv(1, 0, F3_HU,  32'h10, 32'h0,        32'h00007F01, 1, 0);
        addv(1, 0, F3_B,   32'h12, 32'h0,        32'hFFFFFFFF, 1, 0);

        foreach (vt[i]) begin
            do_cycle(0, vt[i].rd, vt[i].wr, vt[i].f3, vt[i].a, vt[i].wd);
            chk($sformatf("vec%0d.dataR", i),  bus.dataR, vt[i].ed);
            chk($sformatf("vec%0d.rvalid", i), 32'(bus.rvalid), 32'(vt[i].ev));
            chk($sformatf("vec%0d.fault", i),  32'(bus.fault), 32'(vt[i].ef));
        end

        // Reset on the same edge as a load and a store.
        do_cycle(1, 1, 0, F3_W, 32'h10, 0);
        chk("rst_load.dataR",  bus.dataR, 32'h0);
        chk("rst_load.rvalid", 32'(bus.rvalid), 32'h0);
        chk("rst_load.fault",  32'(bus.fault), 32'h0);
        do_cycle(1, 0, 1, F3_W, 32'h10, 32'h0BADF00D);
        do_cycle(0, 1, 0, F3_W, 32'h10, 0);
        chk("rst_persist.dataR",  bus.dataR, 32'h80FF7F01);
        chk("rst_persist.rvalid", 32'(bus.rvalid), 32'h1);

        // Misaligned store and load.
        do_cycle(0, 0, 1, F3_W, 32'h40, 32'h0);
        do_cycle(0, 0, 1, F3_W, 32'h41, 32'hFFFFFFFF);
        chk("mis_sw.fault",  32'(bus.fault), 32'(TRAP));
        chk("mis_sw.rvalid", 32'(bus.rvalid), 32'h0);
        do_cycle(0, 1, 0, F3_W, 32'h40, 0);
        chk("mis_sw_mem.dataR", bus.dataR, TRAP ? 32'h0 : 32'hFFFFFFFF);
        chk("mis_sw_pulse.fault", 32'(bus.fault), 32'h0);
        do_cycle(0, 1, 0, F3_H, 32'h43, 0);
        chk("mis_lh.dataR",  bus.dataR, TRAP ? 32'h0 : 32'hFFFFFFFF);
        chk("mis_lh.rvalid", 32'(bus.rvalid), 32'h1);
        chk("mis_lh.fault",  32'(bus.fault), 32'(TRAP));
        do_cycle(0, 0, 0, F3_W, 0, 0);
        chk("mis_lh_pulse.fault", 32'(bus.fault), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[11:8] = 4'h0;
            do_cycle($urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 2) == 0, f3, a, $urandom);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
